// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: sequences the EX-stage multiplier and iterative divider, holding the pipeline
// until the result exists and presenting the HI/LO (or mul GPR) write for the completion cycle.
module hilo_md_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall_hold,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        stallreq,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic [31:0] gpr_wdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [63:0] res;
    logic        idle, legal, take, done;
    logic [2:0]  cur_op;

    assign idle   = state == IDLE && !rst;
    assign legal  = op_code >= 3'd1 && op_code <= 3'd5;
    assign take   = idle && op_valid && legal && !flush;
    assign done   = state == DONE && !flush;
    // The multiplier starts on the raw EX operands in the accept cycle, then runs on the latched copy.
    assign cur_op = idle ? op_code : op_q;

    assign mul_signed = cur_op == 3'd1 || cur_op == 3'd5;
    assign mul_ina    = idle ? src_a : a_q;
    assign mul_inb    = idle ? src_b : b_q;
    assign div_start  = state == DIV_WAIT && !div_ready && !flush;
    assign div_signed = op_q == 3'd3;
    assign div_opa    = a_q;
    assign div_opb    = b_q;
    assign div_annul  = state == DIV_WAIT && flush;
    assign stallreq   = !flush && (take || state == MUL_WAIT || state == DIV_WAIT);
    assign hi_we      = done && op_q != 3'd5;
    assign lo_we      = done && op_q != 3'd5;
    assign hi_wdata   = res[63:32];
    assign lo_wdata   = res[31:0];
    assign gpr_wdata  = done && op_q == 3'd5 ? res[31:0] : '0;
    assign busy       = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res   <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (take) begin
                    op_q <= op_code;
                    a_q  <= src_a;
                    b_q  <= src_b;
                    // Divide by zero never reaches the divider; its architectural result is formed here.
                    if (op_code == 3'd3 || op_code == 3'd4) begin
                        if (src_b == '0) begin
                            state <= DONE;
                            res   <= {src_a, 32'hFFFF_FFFF};
                        end else begin
                            state <= DIV_WAIT;
                        end
                    end else begin
                        state <= MUL_WAIT;
                        cnt   <= 4'(MUL_LAT - 1);
                    end
                end
                MUL_WAIT: if (cnt == '0) begin
                    res   <= mul_result;
                    state <= DONE;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                DIV_WAIT: if (div_ready) begin
                    res   <= div_result;
                    state <= DONE;
                end
                DONE: if (!stall_hold) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
